// File: rtl/axi_lite_imem_loader_if.sv
// AXI4-Lite bus bundle between a host master and the instruction-memory loader.
interface axi_lite_imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_imem_loader.sv
// AXI4-Lite slave that loads program words into the RV32 core and drives its
// run_pc / reset lines from a control register. Write-only program window at
// 0x000, CTRL at 0x400, STATUS at 0x404, WCOUNT at 0x408.
module axi_lite_imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  axi_lite_imem_loader_if.slave s_axi,
  output logic               core_reset_n,
  output logic               core_mem_reset_n,
  output logic               run_pc,
  output logic               instruction_write,
  output logic [31:0]        instruction_data,
  output logic [IMEM_AW-1:0] instruction_addr
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] CTRL_WA   = WA_W'(32'h100);
  localparam logic [WA_W-1:0] STATUS_WA = WA_W'(32'h101);
  localparam logic [WA_W-1:0] WCOUNT_WA = WA_W'(32'h102);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           wstate;
  rstate_t           rstate;
  logic [2:0]        ctrl;      // {mem_rst, core_rst, run}
  logic [CNT_W-1:0]  wcount;
  logic [WA_W-1:0]   aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              aw_got;
  logic              w_got;

  logic              aw_done;
  logic              w_done;
  logic              imem_hit;
  logic [WA_W-1:0]   rd_word;
  logic [31:0]       rd_val;
  logic              rd_err;

  assign core_reset_n     = reset_n & ~ctrl[1];
  assign core_mem_reset_n = ~ctrl[2];
  assign run_pc           = ctrl[0];

  assign aw_done  = aw_got | (s_axi.awvalid & s_axi.awready);
  assign w_done   = w_got  | (s_axi.wvalid  & s_axi.wready);
  assign imem_hit = (aw_addr[WA_W-1:IMEM_AW] == '0);
  assign rd_word  = s_axi.araddr[ADDR_W-1:2];

  // Read-side register mux; IMEM and unmapped addresses return zero with SLVERR.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    if (rd_word == CTRL_WA) begin
      rd_val = {29'b0, ctrl};
      rd_err = 1'b0;
    end else if (rd_word == STATUS_WA) begin
      rd_val = {28'b0, run_pc, core_reset_n, core_mem_reset_n, (wstate != W_IDLE)};
      rd_err = 1'b0;
    end else if (rd_word == WCOUNT_WA) begin
      rd_val = 32'(wcount);
      rd_err = 1'b0;
    end
  end

  // Write channel FSM: collects AW and W in any order, executes for one cycle, then holds B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate            <= W_IDLE;
      ctrl              <= 3'b010;
      wcount            <= '0;
      aw_addr           <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      s_axi.awready     <= 1'b0;
      s_axi.wready      <= 1'b0;
      s_axi.bvalid      <= 1'b0;
      s_axi.bresp       <= '0;
      instruction_write <= 1'b0;
      instruction_data  <= '0;
      instruction_addr  <= '0;
    end else begin
      instruction_write <= 1'b0;
      unique case (wstate)
        W_IDLE: begin
          if (s_axi.awvalid && s_axi.awready) begin
            aw_addr <= s_axi.awaddr[ADDR_W-1:2];
            aw_got  <= 1'b1;
          end
          if (s_axi.wvalid && s_axi.wready) begin
            w_data <= s_axi.wdata;
            w_strb <= s_axi.wstrb;
            w_got  <= 1'b1;
          end
          if (aw_done && w_done) begin
            wstate        <= W_EXEC;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
          end else begin
            s_axi.awready <= ~aw_done;
            s_axi.wready  <= ~w_done;
          end
        end
        W_EXEC: begin
          aw_got       <= 1'b0;
          w_got        <= 1'b0;
          s_axi.bvalid <= 1'b1;
          wstate       <= W_RESP;
          if (imem_hit) begin
            if (w_strb == 4'hF && !ctrl[0]) begin
              instruction_write <= 1'b1;
              instruction_addr  <= aw_addr[IMEM_AW-1:0];
              instruction_data  <= w_data;
              wcount            <= wcount + 1'b1;
              s_axi.bresp       <= RESP_OKAY;
            end else begin
              s_axi.bresp <= RESP_SLVERR;
            end
          end else if (aw_addr == CTRL_WA) begin
            // Only byte lane 0 carries implemented CTRL bits.
            if (w_strb[0]) ctrl <= w_data[2:0];
            s_axi.bresp <= RESP_OKAY;
          end else if (aw_addr == WCOUNT_WA) begin
            wcount      <= '0;
            s_axi.bresp <= RESP_OKAY;
          end else begin
            s_axi.bresp <= RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: data is captured on the AR handshake edge and held until rready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstate        <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          s_axi.arready <= 1'b1;
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rdata   <= rd_val;
            s_axi.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rstate        <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            s_axi.rvalid  <= 1'b0;
            s_axi.arready <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_imem_loader.sv
// Directed bench for axi_lite_imem_loader. A second instance with a 2-bit
// counter mirrors the same bus stimulus so counter wrap can be reached quickly.
module tb_axi_lite_imem_loader;

  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_imem_loader_if #(.ADDR_W(12)) bus ();
  axi_lite_imem_loader_if #(.ADDR_W(12)) bus2 ();

  logic        core_reset_n, core_mem_reset_n, run_pc, instruction_write;
  logic [31:0] instruction_data;
  logic [7:0]  instruction_addr;
  logic        core_reset_n2, core_mem_reset_n2, run_pc2, instruction_write2;
  logic [31:0] instruction_data2;
  logic [7:0]  instruction_addr2;

  axi_lite_imem_loader #(.ADDR_W(12), .IMEM_AW(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_axi(bus),
    .core_reset_n(core_reset_n), .core_mem_reset_n(core_mem_reset_n), .run_pc(run_pc),
    .instruction_write(instruction_write), .instruction_data(instruction_data),
    .instruction_addr(instruction_addr)
  );

  axi_lite_imem_loader #(.ADDR_W(12), .IMEM_AW(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_axi(bus2),
    .core_reset_n(core_reset_n2), .core_mem_reset_n(core_mem_reset_n2), .run_pc(run_pc2),
    .instruction_write(instruction_write2), .instruction_data(instruction_data2),
    .instruction_addr(instruction_addr2)
  );

  assign bus2.awaddr  = bus.awaddr;
  assign bus2.awvalid = bus.awvalid;
  assign bus2.wdata   = bus.wdata;
  assign bus2.wstrb   = bus.wstrb;
  assign bus2.wvalid  = bus.wvalid;
  assign bus2.bready  = bus.bready;
  assign bus2.araddr  = bus.araddr;
  assign bus2.arvalid = bus.arvalid;
  assign bus2.rready  = bus.rready;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  logic [7:0]  last_iaddr;
  logic [31:0] last_idata;

  always @(negedge clk) begin
    if (instruction_write) begin
      strobes++;
      last_iaddr = instruction_addr;
      last_idata = instruction_data;
    end
  end

  typedef struct {
    bit          rd;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    int          hold;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          nstb;
    logic [7:0]  iaddr;
    logic [31:0] idata;
    logic [2:0]  ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add_w(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int awd, input int wd, input int hold, input logic [1:0] resp,
                       input int nstb, input logic [7:0] ia, input logic [31:0] id,
                       input logic [2:0] ctl);
    vec_t v;
    v = '{rd: 1'b0, addr: a, data: d, strb: s, awd: awd, wd: wd, hold: hold, resp: resp,
          rdata: 32'h0, nstb: nstb, iaddr: ia, idata: id, ctl: ctl};
    vecs.push_back(v);
  endtask

  task automatic add_r(input logic [11:0] a, input int hold, input logic [1:0] resp,
                       input logic [31:0] rd, input logic [2:0] ctl);
    vec_t v;
    v = '{rd: 1'b1, addr: a, data: 32'h0, strb: 4'h0, awd: 0, wd: 0, hold: hold, resp: resp,
          rdata: rd, nstb: 0, iaddr: 8'h0, idata: 32'h0, ctl: ctl};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out after %0d cycles waiting for the DUT", name, TO);
  endtask

  // Entered and left at posedge+1.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int hold,
                           output logic [1:0] resp, output bit held, output bit ok);
    bit aw_ok, w_ok, got;
    int n;
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    fork
      begin
        int k;
        bit g;
        k = 0;
        repeat (awd) @(posedge clk);
        if (awd > 0) #1;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        do begin
          @(negedge clk); g = bus.awready; @(posedge clk); #1; k++;
        end while (!g && k < TO);
        bus.awvalid = 1'b0;
        aw_ok = g;
      end
      begin
        int k;
        bit g;
        k = 0;
        repeat (wd) @(posedge clk);
        if (wd > 0) #1;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        do begin
          @(negedge clk); g = bus.wready; @(posedge clk); #1; k++;
        end while (!g && k < TO);
        bus.wvalid = 1'b0;
        w_ok = g;
      end
    join
    ok = aw_ok && w_ok;
    resp = 2'bxx;
    held = 1'b1;
    if (!ok) return;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < TO) begin
      n++;
      @(negedge clk);
    end
    got = bus.bvalid;
    if (!got) begin
      ok = 1'b0;
      @(posedge clk); #1;
      return;
    end
    resp = bus.bresp;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.bvalid || bus.awready || bus.wready) held = 1'b0;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [31:0] data2, output bit stable, output bit ok);
    bit got;
    int n;
    n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    do begin
      @(negedge clk); got = bus.arready; @(posedge clk); #1; n++;
    end while (!got && n < TO);
    bus.arvalid = 1'b0;
    ok = got;
    stable = 1'b1;
    data = 'x;
    data2 = 'x;
    resp = 'x;
    if (!ok) return;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < TO) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rvalid) begin
      ok = 1'b0;
      @(posedge clk); #1;
      return;
    end
    data  = bus.rdata;
    resp  = bus.rresp;
    data2 = bus2.rdata;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp) stable = 1'b0;
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, rd2;
    bit          held, ok;
    int          s0, n;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    //      addr    data          strb  awd wd hold resp   nstb iaddr idata        ctl
    add_r(12'h404, 0, 2'b00, 32'h2, 3'b001);
    add_r(12'h408, 0, 2'b00, 32'h0, 3'b001);
    add_w(12'h00C, 32'h13,        4'hF, 0, 2, 0, 2'b00, 1, 8'h03, 32'h13,       3'b001);
    add_r(12'h408, 0, 2'b00, 32'h1, 3'b001);
    add_w(12'h3FC, 32'hDEADBEEF,  4'hF, 2, 0, 0, 2'b00, 1, 8'hFF, 32'hDEADBEEF, 3'b001);
    add_r(12'h408, 0, 2'b00, 32'h2, 3'b001);
    add_w(12'h020, 32'h12345678,  4'h3, 1, 1, 0, 2'b10, 0, 8'h00, 32'h0,        3'b001);
    add_w(12'h404, 32'hFF,        4'hF, 0, 0, 0, 2'b10, 0, 8'h00, 32'h0,        3'b001);
    add_r(12'h800, 0, 2'b10, 32'h0, 3'b001);
    add_r(12'h000, 0, 2'b10, 32'h0, 3'b001);
    add_r(12'h40C, 0, 2'b10, 32'h0, 3'b001);
    add_w(12'h400, 32'h1,         4'hF, 0, 0, 0, 2'b00, 0, 8'h00, 32'h0,        3'b111);
    add_r(12'h404, 0, 2'b00, 32'hE, 3'b111);
    add_r(12'h400, 5, 2'b00, 32'h1, 3'b111);
    add_w(12'h010, 32'hAA,        4'hF, 0, 0, 5, 2'b10, 0, 8'h00, 32'h0,        3'b111);
    add_r(12'h408, 0, 2'b00, 32'h2, 3'b111);
    add_w(12'h400, 32'h6,         4'h0, 0, 0, 0, 2'b00, 0, 8'h00, 32'h0,        3'b111);
    add_r(12'h400, 0, 2'b00, 32'h1, 3'b111);
    add_w(12'h400, 32'h4,         4'h1, 0, 0, 0, 2'b00, 0, 8'h00, 32'h0,        3'b010);
    add_r(12'h404, 0, 2'b00, 32'h4, 3'b010);
    add_w(12'h402, 32'h0,         4'hF, 0, 0, 0, 2'b00, 0, 8'h00, 32'h0,        3'b011);
    add_r(12'h406, 0, 2'b00, 32'h6, 3'b011);
    add_w(12'h408, 32'h1234,      4'hF, 0, 0, 0, 2'b00, 0, 8'h00, 32'h0,        3'b011);
    add_r(12'h408, 0, 2'b00, 32'h0, 3'b011);
    add_w(12'h00A, 32'h55,        4'hF, 0, 0, 0, 2'b00, 1, 8'h02, 32'h55,       3'b011);
    add_w(12'hC00, 32'h0,         4'hF, 0, 0, 0, 2'b10, 0, 8'h00, 32'h0,        3'b011);
    add_w(12'h40C, 32'h1,         4'hF, 0, 0, 0, 2'b10, 0, 8'h00, 32'h0,        3'b011);
    add_r(12'h408, 0, 2'b00, 32'h1, 3'b011);

    // Reset state and first edge after release.
    repeat (3) @(negedge clk);
    check("reset outputs", {27'b0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 32'h0);
    check("reset strobe", {31'b0, instruction_write}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready after release", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
    check("core lines after reset", {29'b0, run_pc, core_reset_n, core_mem_reset_n}, 32'h1);

    foreach (vecs[i]) begin
      s0 = strobes;
      if (vecs[i].rd) begin
        axi_read(vecs[i].addr, vecs[i].hold, rd, resp, rd2, held, ok);
        if (!ok) timeout_fail($sformatf("v%0d read", i));
        else begin
          check($sformatf("v%0d rresp", i), 32'(resp), 32'(vecs[i].resp));
          check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
          if (vecs[i].hold > 0) check($sformatf("v%0d rdata stable", i), 32'(held), 32'h1);
        end
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].awd, vecs[i].wd,
                  vecs[i].hold, resp, held, ok);
        if (!ok) timeout_fail($sformatf("v%0d write", i));
        else begin
          check($sformatf("v%0d bresp", i), 32'(resp), 32'(vecs[i].resp));
          check($sformatf("v%0d strobes", i), 32'(strobes - s0), 32'(vecs[i].nstb));
          if (vecs[i].nstb > 0) begin
            check($sformatf("v%0d iaddr", i), 32'(last_iaddr), 32'(vecs[i].iaddr));
            check($sformatf("v%0d idata", i), last_idata, vecs[i].idata);
          end
          if (vecs[i].hold > 0) check($sformatf("v%0d bvalid held", i), 32'(held), 32'h1);
        end
      end
      check($sformatf("v%0d core lines", i), {29'b0, run_pc, core_reset_n, core_mem_reset_n},
            32'(vecs[i].ctl));
    end

    // Counter wrap: the 2-bit instance wraps after four loads, the 16-bit one does not.
    axi_write(12'h408, 32'h0, 4'hF, 0, 0, 0, resp, held, ok);
    for (int k = 0; k < 4; k++) axi_write(12'h100 + 12'(4 * k), 32'(k), 4'hF, 0, 0, 0, resp, held, ok);
    axi_read(12'h408, 0, rd, resp, rd2, held, ok);
    if (!ok) timeout_fail("wrap read 1");
    else begin
      check("wcount after 4", rd, 32'h4);
      check("wcount wrap CNT_W=2", rd2, 32'h0);
    end
    axi_write(12'h110, 32'h5, 4'hF, 0, 0, 0, resp, held, ok);
    axi_read(12'h408, 0, rd, resp, rd2, held, ok);
    if (!ok) timeout_fail("wrap read 2");
    else begin
      check("wcount after 5", rd, 32'h5);
      check("wcount post-wrap CNT_W=2", rd2, 32'h1);
    end

    // Reset pulse while the write response is pending.
    bus.awaddr = 12'h030; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < TO);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!bus.bvalid) timeout_fail("bvalid before reset pulse");
    reset_n = 1'b0;
    #1;
    check("bvalid dropped by reset", {28'b0, bus.bvalid, bus.awready, bus.wready, instruction_write}, 32'h0);
    check("core held by reset", {30'b0, core_reset_n, run_pc}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready after reset pulse", {28'b0, bus.awready, bus.wready, bus.arready, bus.bvalid}, 32'he);
    axi_read(12'h404, 0, rd, resp, rd2, held, ok);
    if (!ok) timeout_fail("status after pulse");
    else check("status after pulse", rd, 32'h2);
    axi_read(12'h408, 0, rd, resp, rd2, held, ok);
    if (!ok) timeout_fail("wcount after pulse");
    else check("wcount after pulse", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
